// File: rtl/multiplier_multicycle_pkg.sv
// Shared execute-stage types and constants for the iterative multiplier.
package multiplier_multicycle_pkg;

  typedef logic [63:0]  i64;
  typedef logic [127:0] i128;

  localparam int unsigned MUL_CYCLES = 64;

endpackage

// File: rtl/multiplier_multicycle_mul_abs.sv
// Sign/magnitude split: returns {neg_flag, magnitude} for a value under a signed flag.
module mul_abs #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] value,
  input  logic             is_signed,
  output logic [WIDTH:0]   abs_out
);

  logic neg;

  // The most-negative value negates to itself; read as unsigned it is the true magnitude.
  always_comb begin
    neg     = is_signed & value[WIDTH-1];
    abs_out = {neg, (neg ? (~value + 1'b1) : value)};
  end

endmodule

// File: rtl/multiplier_multicycle.sv
// Radix-2 shift-add multiplier producing the full 2*WIDTH product over CYCLES edges.
module multiplier_multicycle
  import multiplier_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH  = $bits(i64),
  parameter int unsigned CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  logic               a_signed,
  input  logic               b_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;

  logic [WIDTH:0]     abs_a;
  logic [WIDTH:0]     abs_b;
  logic [2*WIDTH-1:0] acc_sum;
  logic               last;

  mul_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value     (a),
    .is_signed (a_signed),
    .abs_out   (abs_a)
  );

  mul_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value     (b),
    .is_signed (b_signed),
    .abs_out   (abs_b)
  );

  always_comb begin
    acc_sum = acc + (mplier[0] ? mcand : '0);
    last    = (count == CW'(CYCLES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!flush && valid) state_next = BUSY;
      BUSY: begin
        if (flush)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath freezes on flush; the next acceptance reloads every register anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      c      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && valid) begin
            mcand  <= {{WIDTH{1'b0}}, abs_a[WIDTH-1:0]};
            mplier <= abs_b[WIDTH-1:0];
            acc    <= '0;
            neg    <= abs_a[WIDTH] ^ abs_b[WIDTH];
            count  <= '0;
          end
        end
        BUSY: begin
          if (!flush) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (last) c <= neg ? (~acc_sum + 1'b1) : acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_multicycle.sv
// Self-checking bench for multiplier_multicycle: cycle model plus directed literal vectors.
module tb_multiplier_multicycle;

  localparam int W      = 64;
  localparam int CYCLES = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid = 1'b0;
  logic          a_signed = 1'b0;
  logic          b_signed = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          flush = 1'b0;
  logic          busy;
  logic          done;
  logic [2*W-1:0] c;

  int tests = 0;
  int fails = 0;
  int ecount = 0;

  multiplier_multicycle #(.WIDTH(W), .CYCLES(CYCLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .a_signed (a_signed),
    .b_signed (b_signed),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .c        (c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic xs, input logic ys);
    logic [2*W-1:0] ex, ey;
    ex = xs ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ey = ys ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return ex * ey;
  endfunction

  // Model: m_t = -1 when idle, otherwise edges elapsed since acceptance.
  int             m_t = -1;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_c = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t <= -1;
      m_c <= '0;
    end else if (m_t < 0) begin
      if (!flush && valid) begin
        m_t    <= 0;
        m_prod <= ref_mul(a, b, a_signed, b_signed);
      end
    end else if (flush || m_t == CYCLES) begin
      m_t <= -1;
    end else begin
      m_t <= m_t + 1;
      if (m_t == CYCLES - 1) m_c <= m_prod;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("busy_model", {127'b0, busy}, {127'b0, (m_t >= 0)});
      check("done_model", {127'b0, done}, {127'b0, (m_t == CYCLES)});
      check("c_model", c, m_c);
    end
  end

  // Entered and left at a negedge in IDLE; optionally scrambles inputs while busy.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tas, input logic tbs, input logic [2*W-1:0] exp,
                        input bit disturb);
    int n, bcnt;
    a = ta; b = tb; a_signed = tas; b_signed = tbs; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    bcnt = busy ? 1 : 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (busy) bcnt++;
      if (disturb && !done) begin
        valid = n[0];
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        a_signed = $urandom_range(0, 1) != 0;
      end
    end
    valid = 1'b0;
    check({name, "_latency"}, 128'(n), 128'(CYCLES));
    check({name, "_c"}, c, exp);
    check({name, "_model_pin"}, m_c, exp);
    @(negedge clk);
    check({name, "_busy_cycles"}, 128'(bcnt), 128'(CYCLES + 1));
    check({name, "_idle_after"}, {127'b0, busy}, '0);
  endtask

  initial begin
    int n, d1, d2, ndone;
    @(negedge clk);
    check("reset_busy", {127'b0, busy}, '0);
    check("reset_done", {127'b0, done}, '0);
    check("reset_c", c, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("u3x5", 64'd3, 64'd5, 1'b0, 1'b0, 128'd15, 1'b0);
    run_op("umax", '1, '1, 1'b0, 1'b0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0);
    run_op("s_m7x3", -64'sd7, 64'd3, 1'b1, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB, 1'b0);
    run_op("s_min_sq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
           128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
    run_op("s_min_m1", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b1,
           128'h0000_0000_0000_0000_8000_0000_0000_0000, 1'b0);
    run_op("hsu", '1, 64'd2, 1'b1, 1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("disturb_6x7", 64'd6, 64'd7, 1'b0, 1'b0, 128'd42, 1'b1);

    // Back-to-back: valid held high, so the second request waits out the DONE bubble.
    a = 64'd2; b = 64'd9; a_signed = 1'b0; b_signed = 1'b0; valid = 1'b1;
    n = 0; ndone = 0; d1 = 0; d2 = 0;
    while (ndone < 2 && n < 400) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (ndone == 0) d1 = ecount; else d2 = ecount;
        ndone++;
      end
    end
    valid = 1'b0;
    check("b2b_two_dones", 128'(ndone), 128'd2);
    check("b2b_spacing", 128'(d2 - d1), 128'(CYCLES + 2));
    check("b2b_c", c, 128'd18);
    @(negedge clk);

    // Flush mid-operation: no completion, old result stays, new request goes next cycle.
    a = 64'd100; b = 64'd100; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (30) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {127'b0, busy}, '0);
    check("flush_c_kept", c, 128'd18);
    run_op("after_flush", 64'd4, 64'd5, 1'b0, 1'b0, 128'd20, 1'b0);

    // Flush beats valid in IDLE.
    flush = 1'b1; valid = 1'b1; a = 64'd9; b = 64'd9;
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    check("flush_idle_reject", {127'b0, busy}, '0);
    check("flush_idle_c", c, 128'd20);

    // Asynchronous reset between edges mid-operation.
    a = 64'd11; b = 64'd13; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_busy", {127'b0, busy}, '0);
    check("areset_done", {127'b0, done}, '0);
    check("areset_c", c, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op("post_reset", 64'd11, 64'd13, 1'b0, 1'b0, 128'd143, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
